alu_result_demux: RTL and testbench

- Result-side counterpart of the ALU source muxes: takes the 16-bit ALU result and routes it to one of four destination holding registers (Zero/One/Two/Three) selected by a 2-bit code.
- Each destination has a valid/ack handshake toward its consumer (stack top, memory data, PC, scratch), with back-pressure to the ALU side.
- Sits between the ALU output and the writeback consumers in the multicycle datapath.

---
 rtl/alu_result_demux.sv | 99 +++++++++
 tb/tb_alu_result_demux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_demux.sv
// alu_result_demux: routes the ALU result into one of four destination
// holding registers (Zero/One/Two/Three) with a valid/ack handshake per
// destination and combinational back-pressure toward the ALU.
// Optional feature: define ALU_DEMUX_COUNT_EN to enable the accept counter;
// otherwise Accept_Count is tied to zero.

// One destination slot: holding register plus its valid flag.
module alu_result_demux_lane #(
  parameter int WIDTH = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             wr,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // Data changes only on a write; a write wins over an ack (refill keeps vld).
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      if (wr) q <= din;
      if (wr)       vld <= 1'b1;
      else if (ack) vld <= 1'b0;
    end
  end

endmodule

module alu_result_demux #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       ALUDest,
  input  logic [WIDTH-1:0] In_Data,
  output logic [WIDTH-1:0] Zero,
  output logic [WIDTH-1:0] One,
  output logic [WIDTH-1:0] Two,
  output logic [WIDTH-1:0] Three,
  output logic [3:0]       Out_Valid,
  input  logic [3:0]       Out_Ack,
  output logic [CNT_W-1:0] Accept_Count
);

  localparam int NUM_DEST = 4;

  logic                           accept;
  logic [NUM_DEST-1:0]            wr;
  logic [NUM_DEST-1:0][WIDTH-1:0] dreg;

  // A slot can take new data when empty or being drained this same cycle.
  assign In_Ready = !Out_Valid[ALUDest] | Out_Ack[ALUDest];
  assign accept   = In_Valid & In_Ready;

  genvar i;
  generate
    for (i = 0; i < NUM_DEST; i++) begin : g_lane
      assign wr[i] = accept & (ALUDest == 2'(i));

      alu_result_demux_lane #(.WIDTH(WIDTH)) u_lane (
        .gclk   (CLK),
        .grst_n (Reset_n),
        .wr     (wr[i]),
        .ack    (Out_Ack[i]),
        .din    (In_Data),
        .q      (dreg[i]),
        .vld    (Out_Valid[i])
      );
    end
  endgenerate

  assign Zero  = dreg[0];
  assign One   = dreg[1];
  assign Two   = dreg[2];
  assign Three = dreg[3];

`ifdef ALU_DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Free-running count of accepted results, wrapping naturally.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)    cnt <= '0;
    else if (accept) cnt <= cnt + CNT_W'(1);
  end

  assign Accept_Count = cnt;
`else
  assign Accept_Count = '0;
`endif

endmodule

// File: tb/tb_alu_result_demux.sv
// Self-checking bench for alu_result_demux: directed test-plan steps plus a
// randomized phase, all compared against a slot-level reference model.
module tb_alu_result_demux;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic          In_Valid;
  logic          In_Ready;
  logic [1:0]    ALUDest;
  logic [W-1:0]  In_Data;
  logic [W-1:0]  Zero, One, Two, Three;
  logic [3:0]    Out_Valid;
  logic [3:0]    Out_Ack;
  logic [CW-1:0] Accept_Count;

  int checks = 0;
  int errors = 0;

  // Reference model: contents and pending flag per destination, plus count.
  logic [W-1:0] m_reg [4];
  bit           m_vld [4];
  int           m_cnt;

  alu_result_demux #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .In_Valid     (In_Valid),
    .In_Ready     (In_Ready),
    .ALUDest      (ALUDest),
    .In_Data      (In_Data),
    .Zero         (Zero),
    .One          (One),
    .Two          (Two),
    .Three        (Three),
    .Out_Valid    (Out_Valid),
    .Out_Ack      (Out_Ack),
    .Accept_Count (Accept_Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_reg[k] = '0;
      m_vld[k] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic logic [3:0] m_vld_vec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_vld[k];
    return v;
  endfunction

  function automatic int exp_count();
`ifdef ALU_DEMUX_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".zero"},  32'(Zero),         32'(m_reg[0]));
    chk({tag, ".one"},   32'(One),          32'(m_reg[1]));
    chk({tag, ".two"},   32'(Two),          32'(m_reg[2]));
    chk({tag, ".three"}, 32'(Three),        32'(m_reg[3]));
    chk({tag, ".vld"},   32'(Out_Valid),    32'(m_vld_vec()));
    chk({tag, ".cnt"},   32'(Accept_Count), 32'(exp_count()));
  endtask

  // One clock of traffic, called shortly after a rising edge.
  task automatic cycle(input string tag, input logic v, input logic [1:0] d,
                       input logic [W-1:0] x, input logic [3:0] ack);
    bit rdy;
    In_Valid = v; ALUDest = d; In_Data = x; Out_Ack = ack;
    #1;
    rdy = !m_vld[d] || ack[d];
    chk({tag, ".ready"}, 32'(In_Ready), 32'(rdy));
    @(posedge CLK); #1;
    for (int k = 0; k < 4; k++) if (ack[k]) m_vld[k] = 1'b0;
    if (v && rdy) begin
      m_reg[d] = x;
      m_vld[d] = 1'b1;
      m_cnt    = (m_cnt + 1) % (1 << CW);
    end
    check_outs(tag);
  endtask

  initial begin
    // Reset held with a result offered: nothing may be captured.
    Reset_n = 1'b0; In_Valid = 1'b1; In_Data = 16'hBEEF; ALUDest = 2'd2; Out_Ack = 4'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_outs("rst");
    chk("rst.ready", 32'(In_Ready), 32'd1);
    Reset_n = 1'b1;
    cycle("rst_rel", 1'b1, 2'd2, 16'hBEEF, 4'b0000);
    chk("rst_rel.two", 32'(Two), 32'h0000BEEF);
    chk("rst_rel.vld", 32'(Out_Valid), 32'b0100);
    cycle("clr0", 1'b0, 2'd0, '0, 4'b1111);

    // Sweep: each destination gets its own index, acked the next cycle.
    for (int d = 0; d < 4; d++)
      cycle("sweep", 1'b1, 2'(d), W'(d), (d == 0) ? 4'b0000 : 4'(1 << (d - 1)));
    cycle("sweep_end", 1'b0, 2'd0, '0, 4'b1000);
    chk("sweep.vld", 32'(Out_Valid), 32'd0);

    // Back-pressure on One.
    cycle("bp_fill",  1'b1, 2'd1, 16'h1234, 4'b0000);
    cycle("bp_stall", 1'b1, 2'd1, 16'h5678, 4'b0000);
    chk("bp_stall.one", 32'(One), 32'h1234);
    cycle("bp_ack",   1'b1, 2'd1, 16'h5678, 4'b0010);
    chk("bp_ack.one", 32'(One), 32'h5678);
    chk("bp_ack.vld1", 32'(Out_Valid[1]), 32'd1);
    cycle("clr1", 1'b0, 2'd0, '0, 4'b1111);

    // Independent destinations plus a spurious ack on an empty slot.
    cycle("ind_z", 1'b1, 2'd0, 16'h0011, 4'b0000);
    cycle("ind_3", 1'b1, 2'd3, 16'h00AA, 4'b0100);
    chk("ind.vld", 32'(Out_Valid), 32'b1001);
    chk("ind.three", 32'(Three), 32'h00AA);

    // Asynchronous reset between edges with all slots full.
    for (int d = 0; d < 4; d++) cycle("fill", 1'b1, 2'(d), 16'hA500 | W'(d), 4'b0000);
    chk("fill.vld", 32'(Out_Valid), 32'b1111);
    In_Valid = 1'b0; Out_Ack = 4'b0;
    #1 Reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    chk("arst.ready", 32'(In_Ready), 32'd1);
    #1 Reset_n = 1'b1;
    @(posedge CLK); #1;
    check_outs("arst_rel");

    // 257 back-to-back accepts to one slot with continuous ack.
    for (int n = 0; n < 257; n++)
      cycle("b2b", 1'b1, 2'd0, W'($urandom), 4'b0001);
`ifdef ALU_DEMUX_COUNT_EN
    chk("b2b.count", 32'(Accept_Count), 32'd1);
`else
    chk("b2b.count", 32'(Accept_Count), 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            W'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
